// File: rtl/lru_stack_p.sv
// lru_stack_p: DEPTH-entry page-tag LRU stack, MRU at entry 0, LRU at entry DEPTH-1.
// Touch/fill/demote commands complete in one cycle. The LRU tag is always presented
// as the replacement victim.
// Optional hit/miss statistics counters are enabled with `define LRU_STAT_EN.
module lru_stack_p #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned RST_BASE = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [1:0]        iLRU_Op,
   input  logic [ADDR_W-1:0] iLRU_PAddr,
   output logic              oLRU_Hit,
   output logic [IDX_W-1:0]  oLRU_HitIdx,
   output logic              oLRU_Done,
   output logic [ADDR_W-1:0] oLRU_PAddr
`ifdef LRU_STAT_EN
   ,
   input  logic              iLRU_StatClr,
   output logic [15:0]       oLRU_HitCnt,
   output logic [15:0]       oLRU_MissCnt
`endif
);

   localparam int DEPTH = 1 << IDX_W;

   localparam logic [1:0] OP_NONE   = 2'b00;
   localparam logic [1:0] OP_TOUCH  = 2'b01;
   localparam logic [1:0] OP_FILL   = 2'b10;
   localparam logic [1:0] OP_DEMOTE = 2'b11;

   logic [ADDR_W-1:0] r_stack [DEPTH];
   logic [ADDR_W-1:0] w_stack_d [DEPTH];
   logic              r_hit;
   logic [IDX_W-1:0]  r_hit_idx;
   logic              r_done;
   logic              w_hit;
   logic [IDX_W-1:0]  w_hit_idx;
   logic              w_cmd;

   assign w_cmd = (iLRU_Op != OP_NONE);

   // Parallel tag compare; scanning downwards lets the lowest matching index win.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_stack[i] == iLRU_PAddr) begin
            w_hit     = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
      end
   end

   // Next stack contents for the current command.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_stack_d[i] = r_stack[i];
      end
      case (iLRU_Op)
         OP_TOUCH, OP_FILL: begin
            if (w_hit) begin
               // Promote to MRU: entries above the hit slide down, entries below stay.
               w_stack_d[0] = iLRU_PAddr;
               for (int i = 1; i < DEPTH; i++) begin
                  if (i <= int'(w_hit_idx)) begin
                     w_stack_d[i] = r_stack[i-1];
                  end
               end
            end else if (iLRU_Op == OP_FILL) begin
               // Insert at MRU and push the old LRU tag out.
               w_stack_d[0] = iLRU_PAddr;
               for (int i = 1; i < DEPTH; i++) begin
                  w_stack_d[i] = r_stack[i-1];
               end
            end
         end
         OP_DEMOTE: begin
            if (w_hit) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  if (i >= int'(w_hit_idx)) begin
                     w_stack_d[i] = r_stack[i+1];
                  end
               end
               w_stack_d[DEPTH-1] = iLRU_PAddr;
            end
         end
         default: ;
      endcase
   end

   // Stack and status registers; reset drops any coincident command.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_stack[k] <= ADDR_W'(RST_BASE + 32'(k));
         end
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
         r_done    <= 1'b0;
      end else begin
         r_stack <= w_stack_d;
         r_done  <= w_cmd;
         if (w_cmd) begin
            r_hit     <= w_hit;
            r_hit_idx <= w_hit_idx;
         end
      end
   end

   assign oLRU_Hit    = r_hit;
   assign oLRU_HitIdx = r_hit_idx;
   assign oLRU_Done   = r_done;
   assign oLRU_PAddr  = r_stack[DEPTH-1];

`ifdef LRU_STAT_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;

   // Saturating hit/miss counters; clear beats any increment in the same cycle.
   always_ff @(posedge Clk) begin
      if (!Reset || iLRU_StatClr) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_cmd) begin
         if (w_hit && (r_hit_cnt != 16'hFFFF)) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
         end
         if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
         end
      end
   end

   assign oLRU_HitCnt  = r_hit_cnt;
   assign oLRU_MissCnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_lru_stack_p.sv
// Self-checking bench for lru_stack_p (ADDR_W=4, IDX_W=3) plus a DEPTH=2 instance.
// Statistics checks are compiled in when LRU_STAT_EN is defined.
module tb_lru_stack_p;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] op;
   logic [3:0] addr;
   logic       hit;
   logic [2:0] hit_idx;
   logic       done;
   logic [3:0] lru;

   logic       rst2_n;
   logic [1:0] op2;
   logic [3:0] addr2;
   logic       hit2;
   logic [0:0] hit_idx2;
   logic       done2;
   logic [3:0] lru2;

`ifdef LRU_STAT_EN
   logic        stat_clr;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
   logic        stat_clr2;
   logic [15:0] hit_cnt2;
   logic [15:0] miss_cnt2;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lru_stack_p #(.ADDR_W(4), .IDX_W(3), .RST_BASE(0)) u_dut (
      .Clk         (clk),
      .Reset       (rst_n),
      .iLRU_Op     (op),
      .iLRU_PAddr  (addr),
      .oLRU_Hit    (hit),
      .oLRU_HitIdx (hit_idx),
      .oLRU_Done   (done),
      .oLRU_PAddr  (lru)
`ifdef LRU_STAT_EN
      ,
      .iLRU_StatClr(stat_clr),
      .oLRU_HitCnt (hit_cnt),
      .oLRU_MissCnt(miss_cnt)
`endif
   );

   lru_stack_p #(.ADDR_W(4), .IDX_W(1), .RST_BASE(0)) u_dut2 (
      .Clk         (clk),
      .Reset       (rst2_n),
      .iLRU_Op     (op2),
      .iLRU_PAddr  (addr2),
      .oLRU_Hit    (hit2),
      .oLRU_HitIdx (hit_idx2),
      .oLRU_Done   (done2),
      .oLRU_PAddr  (lru2)
`ifdef LRU_STAT_EN
      ,
      .iLRU_StatClr(stat_clr2),
      .oLRU_HitCnt (hit_cnt2),
      .oLRU_MissCnt(miss_cnt2)
`endif
   );

   typedef struct {
      logic [1:0] op;
      logic [3:0] addr;
      logic       rst_n;
      logic       hit;
      logic [2:0] idx;
      logic       done;
      logic [3:0] lru;
   } vec_t;

   typedef struct {
      logic       hit;
      logic [2:0] idx;
      logic       done;
      logic [3:0] lru;
      logic [31:0] stk;
   } exp_t;

   vec_t       tbl [17];
   exp_t       sb_q [$];
   logic [3:0] m_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference stack kept as a queue: MRU at the front, LRU at the back.
   task automatic model_step(input logic [1:0] mop, input logic [3:0] maddr,
                             input logic mrst_n);
      int h;
      if (!mrst_n) begin
         m_q = {};
         for (int k = 0; k < 8; k++) m_q.push_back(4'(k));
         return;
      end
      h = -1;
      for (int k = 0; k < m_q.size(); k++) begin
         if (h < 0 && m_q[k] == maddr) h = k;
      end
      if (mop == 2'b01 || mop == 2'b10) begin
         if (h >= 0) begin
            m_q.delete(h);
            m_q.push_front(maddr);
         end else if (mop == 2'b10) begin
            m_q.push_front(maddr);
            void'(m_q.pop_back());
         end
      end else if (mop == 2'b11 && h >= 0) begin
         m_q.delete(h);
         m_q.push_back(maddr);
      end
   endtask

   function automatic logic [31:0] model_flat();
      logic [31:0] f;
      for (int k = 0; k < 8; k++) f[k*4 +: 4] = m_q[k];
      return f;
   endfunction

   function automatic logic [31:0] dut_flat();
      logic [31:0] f;
      for (int k = 0; k < 8; k++) f[k*4 +: 4] = u_dut.r_stack[k];
      return f;
   endfunction

   // One cycle: drive at negedge, push expectation, compare 1 ns after the edge.
   task automatic issue(input string name, input logic [1:0] iop, input logic [3:0] iaddr,
                        input logic irst_n, input logic ehit, input logic [2:0] eidx,
                        input logic edone, input logic [3:0] elru);
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst_n = irst_n;
      op    = iop;
      addr  = iaddr;
      model_step(iop, iaddr, irst_n);
      e.hit  = ehit;
      e.idx  = eidx;
      e.done = edone;
      e.lru  = elru;
      e.stk  = model_flat();
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      chk({name, ".hit"},  32'(hit),     32'(g.hit));
      chk({name, ".idx"},  32'(hit_idx), 32'(g.idx));
      chk({name, ".done"}, 32'(done),    32'(g.done));
      chk({name, ".lru"},  32'(lru),     32'(g.lru));
      chk({name, ".stk"},  dut_flat(),   g.stk);
   endtask

   task automatic issue2(input logic [1:0] iop, input logic [3:0] iaddr, input logic irst_n);
      @(negedge clk);
      rst2_n = irst_n;
      op2    = iop;
      addr2  = iaddr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = 2'b00; addr = 4'd0;
      rst2_n = 1'b0; op2 = 2'b00; addr2 = 4'd0;
`ifdef LRU_STAT_EN
      stat_clr = 1'b0; stat_clr2 = 1'b0;
`endif

      //         op     addr   rst   hit   idx   done  lru
      tbl[0]  = '{2'b00, 4'd0,  1'b0, 1'b0, 3'd0, 1'b0, 4'd7};  // reset
      tbl[1]  = '{2'b01, 4'd5,  1'b1, 1'b1, 3'd5, 1'b1, 4'd7};  // touch 5
      tbl[2]  = '{2'b01, 4'd7,  1'b1, 1'b1, 3'd7, 1'b1, 4'd6};  // touch 7 (LRU)
      tbl[3]  = '{2'b00, 4'd3,  1'b1, 1'b1, 3'd7, 1'b0, 4'd6};  // idle holds hit/idx
      tbl[4]  = '{2'b01, 4'd9,  1'b1, 1'b0, 3'd0, 1'b1, 4'd6};  // touch miss
      tbl[5]  = '{2'b01, 4'd7,  1'b1, 1'b1, 3'd0, 1'b1, 4'd6};  // touch at MRU
      tbl[6]  = '{2'b00, 4'd0,  1'b0, 1'b0, 3'd0, 1'b0, 4'd7};  // reset
      tbl[7]  = '{2'b10, 4'd12, 1'b1, 1'b0, 3'd0, 1'b1, 4'd6};  // fill miss
      tbl[8]  = '{2'b10, 4'd12, 1'b1, 1'b1, 3'd0, 1'b1, 4'd6};  // fill hit at 0
      tbl[9]  = '{2'b00, 4'd0,  1'b0, 1'b0, 3'd0, 1'b0, 4'd7};  // reset
      tbl[10] = '{2'b11, 4'd2,  1'b1, 1'b1, 3'd2, 1'b1, 4'd2};  // demote 2
      tbl[11] = '{2'b11, 4'd9,  1'b1, 1'b0, 3'd0, 1'b1, 4'd2};  // demote miss
      tbl[12] = '{2'b11, 4'd2,  1'b1, 1'b1, 3'd7, 1'b1, 4'd2};  // demote at LRU
      tbl[13] = '{2'b10, 4'd2,  1'b1, 1'b1, 3'd7, 1'b1, 4'd7};  // fill hit acts as touch
      tbl[14] = '{2'b01, 4'd3,  1'b0, 1'b0, 3'd0, 1'b0, 4'd7};  // reset beats touch
      tbl[15] = '{2'b10, 4'd3,  1'b1, 1'b1, 3'd3, 1'b1, 4'd7};  // fill hit at 3
      tbl[16] = '{2'b00, 4'd0,  1'b0, 1'b0, 3'd0, 1'b0, 4'd7};  // reset

      for (int i = 0; i < 17; i++) begin
         issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].rst_n,
               tbl[i].hit, tbl[i].idx, tbl[i].done, tbl[i].lru);
      end

      // Eight back-to-back fills 8..15: each misses and evicts the current LRU.
      for (int j = 0; j < 8; j++) begin
         issue($sformatf("fill%0d", 8 + j), 2'b10, 4'(8 + j), 1'b1, 1'b0, 3'd0, 1'b1,
               (j < 7) ? 4'(6 - j) : 4'd8);
      end
      chk("fills.final", dut_flat(), 32'h89AB_CDEF);

      // DEPTH=2 instance: fills and touches swap the two entries.
      issue2(2'b00, 4'd0, 1'b0);
      chk("d2.rst.lru", 32'(lru2), 32'd1);
      chk("d2.rst.done", 32'(done2), 32'd0);
      issue2(2'b10, 4'd5, 1'b1);
      chk("d2.fill5.lru", 32'(lru2), 32'd0);
      chk("d2.fill5.hit", 32'(hit2), 32'd0);
      issue2(2'b10, 4'd0, 1'b1);
      chk("d2.fill0.lru", 32'(lru2), 32'd5);
      chk("d2.fill0.idx", 32'(hit_idx2), 32'd1);
      issue2(2'b01, 4'd5, 1'b1);
      chk("d2.touch5.lru", 32'(lru2), 32'd0);
      chk("d2.touch5.hit", 32'(hit2), 32'd1);

`ifdef LRU_STAT_EN
      issue("st.rst", 2'b00, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd7);
      chk("st.rst.hcnt", 32'(hit_cnt), 32'd0);
      issue("st.h0", 2'b01, 4'd0, 1'b1, 1'b1, 3'd0, 1'b1, 4'd7);
      issue("st.h1", 2'b11, 4'd6, 1'b1, 1'b1, 3'd6, 1'b1, 4'd6);
      issue("st.m0", 2'b01, 4'd9, 1'b1, 1'b0, 3'd0, 1'b1, 4'd6);
      issue("st.idle", 2'b00, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd6);
      issue("st.m1", 2'b11, 4'd10, 1'b1, 1'b0, 3'd0, 1'b1, 4'd6);
      issue("st.h2", 2'b01, 4'd0, 1'b1, 1'b1, 3'd0, 1'b1, 4'd6);
      chk("st.hcnt3", 32'(hit_cnt), 32'd3);
      chk("st.mcnt2", 32'(miss_cnt), 32'd2);
      stat_clr = 1'b1;
      issue("st.clr", 2'b01, 4'd0, 1'b1, 1'b1, 3'd0, 1'b1, 4'd6);
      stat_clr = 1'b0;
      chk("st.clr.hcnt", 32'(hit_cnt), 32'd0);
      chk("st.clr.mcnt", 32'(miss_cnt), 32'd0);
      // Touching the MRU tag hits without moving the stack; run past saturation.
      @(negedge clk);
      op = 2'b01; addr = 4'd0;
      for (int j = 0; j < 65535; j++) @(posedge clk);
      #1;
      chk("st.sat.reach", 32'(hit_cnt), 32'hFFFF);
      issue("st.sat", 2'b01, 4'd0, 1'b1, 1'b1, 3'd0, 1'b1, 4'd6);
      chk("st.sat.hold", 32'(hit_cnt), 32'hFFFF);
      chk("st.sat.mcnt", 32'(miss_cnt), 32'd0);
`endif

      @(negedge clk);
      op = 2'b00;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lru_stack_p.md
Name: lru_stack_p

Overview:
- Parametrised successor to the 8-entry page LRU in the VMU.
- Holds DEPTH unique page tags ordered MRU (entry 0) to LRU (entry DEPTH-1).
- Supports touch, fill and demote commands, reports hit, hit index and a one-cycle done strobe.
- Continuously presents the LRU page as the replacement victim for the VMU page-fault path.

Parameters:
- ADDR_W, 3, page-tag width in bits (tPADDR width).
- IDX_W, 3, index width; DEPTH = 2**IDX_W entries, legal range 1..5.
- RST_BASE, 0, entry k resets to tag (RST_BASE + k) truncated to ADDR_W. Must yield DEPTH distinct tags.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset; Reset==0 at a Clk edge resets the block.
- iLRU_Op  in  2  command: 00 none, 01 touch, 10 fill, 11 demote. Sampled every cycle, no back-pressure.
- iLRU_PAddr  in  ADDR_W  page tag for the command.
- oLRU_Hit  out  1  registered: tag matched an entry on the last command.
- oLRU_HitIdx  out  IDX_W  registered: pre-update position of the match, 0 on miss.
- oLRU_Done  out  1  registered one-cycle pulse per accepted non-00 command.
- oLRU_PAddr  out  ADDR_W  current LRU tag (entry DEPTH-1), driven straight from the register.

Behaviour:
- Reset (Reset==0): entry k <= RST_BASE+k. oLRU_Hit=0, oLRU_HitIdx=0, oLRU_Done=0. oLRU_PAddr = RST_BASE+DEPTH-1 from the next cycle.
- Compare: iLRU_PAddr is compared against every entry in parallel. If several match (illegal), the lowest index wins.
- Every command completes in one cycle. Stack update, oLRU_Hit, oLRU_HitIdx and oLRU_Done are all visible after the same Clk edge. Back-to-back commands are legal every cycle.
- Op 00: stack held; Done=0; Hit and HitIdx hold their previous values.
- Touch, hit at index h: entry0 <= tag; entries 0..h-1 shift down by one; entries above h unchanged. Hit=1, HitIdx=h.
- Touch, miss: stack unchanged; Hit=0.
- Fill, miss: entry0 <= tag; all entries shift down by one; the old LRU tag is discarded. Hit=0.
- Fill, hit: behaves exactly as touch. No duplicate tags are ever created. Hit=1.
- Demote, hit at h: entry DEPTH-1 <= tag; entries h+1..DEPTH-1 shift up by one. Hit=1, HitIdx=h.
- Demote, miss: no change; Hit=0.
- Boundaries:
  - Touch at h=0 leaves the stack unchanged.
  - Demote at h=DEPTH-1 leaves the stack unchanged.
  - DEPTH=2 with a fill swaps as expected.
- Reset asserted together with a command: reset wins and the command is dropped.
- An X or Z in iLRU_Op or iLRU_PAddr is not masked. The bench keeps inputs known whenever Op != 00.

Optional Feature:
- Macro LRU_STAT_EN.
- Defined:
  - Adds outputs oLRU_HitCnt[15:0] and oLRU_MissCnt[15:0], both reset to 0.
  - Each increments once per touch/fill/demote that hits or misses respectively, saturating at 16'hFFFF.
  - Op 00 does not count.
  - Adds input iLRU_StatClr; when 1, both counters clear that cycle and the clear overrides any increment.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset with defaults -> stack {0,1,2,3,4,5,6,7}, oLRU_PAddr=7, Hit/Done=0.
- Touch 5 -> Hit=1, HitIdx=5, Done pulse, stack {5,0,1,2,3,4,6,7}. Then touch 7 -> HitIdx=7, stack {7,5,0,1,2,3,4,6}, oLRU_PAddr=6.
- ADDR_W=4: fill 12 after reset -> Hit=0, stack {12,0,..,6}, oLRU_PAddr=6. Fill 12 again -> Hit=1, HitIdx=0, stack unchanged.
- Demote 2 after reset -> HitIdx=2, stack {0,1,3,4,5,6,7,2}, oLRU_PAddr=2. Demote 9 (ADDR_W=4) -> Hit=0, no change.
- Touch 3 issued with Reset=0 in the same cycle -> stack is the reset order, Done=0. Eight back-to-back fills 8..15 -> stack {15..8}, one Done per cycle.
- LRU_STAT_EN: 3 hits, 2 misses -> HitCnt=3, MissCnt=2. iLRU_StatClr asserted with a hit in the same cycle -> both 0. HitCnt preset to 16'hFFFF + one hit -> stays 16'hFFFF.
